// File: rtl/lmdpl_dualrail_seq.sv
// lmdpl_dualrail_seq
//   Sequencing register for an LMDPL dual-rail masked network with N channels.
//   Each round runs a precharge phase and then an evaluate phase. During
//   evaluation every channel's dual-rail pair is captured once, and the
//   capture is monotonic. At the end of the round the block pulses done or
//   timeout. Rail violations raise a sticky fault flag.
//
// Optional feature (macro LMDPL_FAULT_CNT_EN):
//   Adds fault_cnt[7:0], a saturating count of cycles that contained at
//   least one violation.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      request one round; only sampled in IDLE
//   in_t/in_f  true/false rails from the LMDPL network
//   fault_clr  clears the sticky fault flag (a new violation wins)
//   prech      network in precharge
//   eval       network evaluating
//   busy       round in progress (PRE or EVAL)
//   q_t/q_f    captured true/false rails
//   done       one-cycle pulse: all channels resolved
//   timeout    one-cycle pulse: evaluate window expired with unresolved channels
//   fault      sticky dual-rail violation flag
//   fault_cnt  (LMDPL_FAULT_CNT_EN only) saturating violation-cycle count
module lmdpl_dualrail_seq #(
  parameter int unsigned N          = 8,
  parameter int unsigned PRE_CYCLES = 1,
  parameter int unsigned EVAL_MAX   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in_t,
  input  logic [N-1:0] in_f,
  input  logic         fault_clr,
  output logic         prech,
  output logic         eval,
  output logic         busy,
  output logic [N-1:0] q_t,
  output logic [N-1:0] q_f,
  output logic         done,
  output logic         timeout,
`ifdef LMDPL_FAULT_CNT_EN
  output logic [7:0]   fault_cnt,
`endif
  output logic         fault
);

  localparam int unsigned CntMax = (PRE_CYCLES > EVAL_MAX) ? PRE_CYCLES : EVAL_MAX;
  localparam int unsigned CW     = $clog2(CntMax) + 1;

  typedef enum logic [1:0] {StIdle, StPre, StEval} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_t_q, q_t_d, q_f_q, q_f_d;
  logic [N-1:0]   cap_q, cap_d;
  logic [N-1:0]   res, both;
  logic           done_q, done_d, timeout_q, timeout_d;
  logic           fault_q, fault_d;
  logic           prech_q, eval_q, busy_q;
  logic           viol;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_t_d     = q_t_q;
    q_f_d     = q_f_q;
    cap_d     = cap_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    viol      = 1'b0;
    res       = '0;
    both      = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPre;
          cnt_d   = CW'(PRE_CYCLES - 1);
          q_t_d   = '0;
          q_f_d   = '0;
          cap_d   = '0;
        end
      end
      StPre: begin
        if (cnt_q == '0) begin
          // Rails must be fully discharged at the end of precharge.
          viol    = |(in_t | in_f);
          state_d = StEval;
          cnt_d   = CW'(EVAL_MAX - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StEval: begin
        // Only still-open channels are looked at; captured ones are frozen.
        res   = (in_t ^ in_f) & ~cap_q;
        both  = in_t & in_f & ~cap_q;
        viol  = |both;
        q_t_d = (q_t_q & ~res) | (in_t & res);
        q_f_d = (q_f_q & ~res) | (in_f & res);
        cap_d = cap_q | res;
        if (&cap_d) begin
          done_d  = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    fault_d = viol ? 1'b1 : (fault_clr ? 1'b0 : fault_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      q_t_q     <= '0;
      q_f_q     <= '0;
      cap_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
      prech_q   <= 1'b1;
      eval_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_t_q     <= q_t_d;
      q_f_q     <= q_f_d;
      cap_q     <= cap_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
      prech_q   <= (state_d != StEval);
      eval_q    <= (state_d == StEval);
      busy_q    <= (state_d != StIdle);
    end
  end

`ifdef LMDPL_FAULT_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (viol) begin
      if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
    end else if (fault_clr) begin
      fcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end

  assign fault_cnt = fcnt_q;
`endif

  assign prech   = prech_q;
  assign eval    = eval_q;
  assign busy    = busy_q;
  assign q_t     = q_t_q;
  assign q_f     = q_f_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign fault   = fault_q;

endmodule
